// File: rtl/reg_file_2r1w_if.sv
`default_nettype none
// ============================================================================
// Module      : reg_file_2r1w_if
// Description : Bus bundle for the 2-read / 1-write register file.
//               Carries the masked write request, two read address/data
//               pairs, the sweep-clear request and the status pulses.
//               master = requester side, slave = register file side.
// Revision    : 1.0 - initial release
// ============================================================================
interface reg_file_2r1w_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
);
  localparam int AW = $clog2(DEPTH);

  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic [WIDTH-1:0] wr_mask;
  logic [AW-1:0]    rd0_addr;
  logic [AW-1:0]    rd1_addr;
  logic [WIDTH-1:0] rd0_data;
  logic [WIDTH-1:0] rd1_data;
  logic             clr_req;
  logic             busy;
  logic             clr_done;
  logic             wr_err;

  modport master (
    output wr_en, wr_addr, wr_data, wr_mask, rd0_addr, rd1_addr, clr_req,
    input  rd0_data, rd1_data, busy, clr_done, wr_err
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, wr_mask, rd0_addr, rd1_addr, clr_req,
    output rd0_data, rd1_data, busy, clr_done, wr_err
  );
endinterface
`default_nettype wire

// File: rtl/reg_file_2r1w.sv
`default_nettype none
// ============================================================================
// Module      : reg_file_2r1w
// Description : DEPTH x WIDTH register file, one bit-masked write port and
//               two independent combinational read ports, with a sweep-clear
//               engine that zeroes one entry per cycle.
// Revision    : 1.0 - initial release
// Options     : REG_FILE_BYPASS_EN - when defined, an accepted write is
//               forwarded to a read port addressing the same entry in the
//               same cycle. Undefined: reads always show stored contents.
// Ports       : clk      - clock, rising edge
//               reset    - asynchronous active-high reset
//               bus      - reg_file_2r1w_if.slave:
//                 wr_en/wr_addr/wr_data/wr_mask  masked write request
//                 rd0_addr/rd1_addr -> rd0_data/rd1_data  combinational reads
//                 clr_req  start sweep-clear   busy      sweep in progress
//                 clr_done sweep-end pulse     wr_err    dropped-write pulse
// ============================================================================
module reg_file_2r1w #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  wire logic        clk,
  input  wire logic        reset,
  reg_file_2r1w_if.slave   bus
);
  localparam int AW = $clog2(DEPTH);

  localparam logic [0:0]    c_IDLE  = 1'b0;
  localparam logic [0:0]    c_CLEAR = 1'b1;
  localparam logic [AW-1:0] c_LAST  = AW'(DEPTH - 1);
  localparam logic [AW-1:0] c_ONE   = AW'(1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [0:0]       r_state;
  logic [AW-1:0]    r_ptr;
  logic             r_busy;
  logic             r_clr_done;
  logic             r_wr_err;

  logic             w_idle;
  logic             w_wr_acc;
  logic             w_wr_drop;
  logic [WIDTH-1:0] w_merged;
  logic [WIDTH-1:0] w_rd0;
  logic [WIDTH-1:0] w_rd1;

  // A clear request sampled in IDLE takes priority over a same-cycle write.
  assign w_idle    = (r_state == c_IDLE);
  assign w_wr_acc  = w_idle & bus.wr_en & ~bus.clr_req;
  assign w_wr_drop = bus.wr_en & ~w_wr_acc;
  assign w_merged  = (r_mem[bus.wr_addr] & ~bus.wr_mask) |
                     (bus.wr_data & bus.wr_mask);

  // Sweep control: busy is a registered copy of "in CLEAR" so it rises the
  // cycle after clr_req is sampled and stays up for exactly DEPTH cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= c_IDLE;
      r_ptr      <= '0;
      r_busy     <= 1'b0;
      r_clr_done <= 1'b0;
      r_wr_err   <= 1'b0;
    end else begin
      r_clr_done <= 1'b0;
      r_wr_err   <= w_wr_drop;
      case (r_state)
        c_IDLE: begin
          if (bus.clr_req) begin
            r_state <= c_CLEAR;
            r_ptr   <= '0;
            r_busy  <= 1'b1;
          end
        end
        c_CLEAR: begin
          r_ptr <= r_ptr + c_ONE;
          if (r_ptr == c_LAST) begin
            r_state    <= c_IDLE;
            r_busy     <= 1'b0;
            r_clr_done <= 1'b1;
          end
        end
        default: begin
          r_state <= c_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Storage: the sweep owns the array while in CLEAR; writes only in IDLE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (r_state == c_CLEAR) begin
      r_mem[r_ptr] <= '0;
    end else if (w_wr_acc) begin
      r_mem[bus.wr_addr] <= w_merged;
    end
  end

  always_comb begin
    w_rd0 = r_mem[bus.rd0_addr];
    w_rd1 = r_mem[bus.rd1_addr];
`ifdef REG_FILE_BYPASS_EN
    if (w_wr_acc && (bus.rd0_addr == bus.wr_addr)) begin
      w_rd0 = w_merged;
    end
    if (w_wr_acc && (bus.rd1_addr == bus.wr_addr)) begin
      w_rd1 = w_merged;
    end
`else
    // Stored contents only; new data appears the cycle after the write edge.
`endif
  end

  assign bus.rd0_data = w_rd0;
  assign bus.rd1_data = w_rd1;
  assign bus.busy     = r_busy;
  assign bus.clr_done = r_clr_done;
  assign bus.wr_err   = r_wr_err;

endmodule
`default_nettype wire

// File: tb/tb_reg_file_2r1w.sv
`default_nettype none
// ============================================================================
// Module      : tb_reg_file_2r1w
// Description : Self-checking bench for reg_file_2r1w (WIDTH=8, DEPTH=4):
//               directed vector table, hand-written sweep/reset sequences,
//               and randomized traffic against an array-based model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_file_2r1w;
  localparam int WIDTH = 8;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  reg_file_2r1w_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  reg_file_2r1w #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: plain array plus "entries left to sweep".
  logic [7:0] m_mem [DEPTH];
  int         m_left;
  logic       m_done;
  logic       m_err;

  typedef struct {
    logic       we;
    logic [1:0] wa;
    logic [7:0] wd;
    logic [7:0] wm;
    logic [1:0] r0;
    logic [1:0] r1;
    logic [7:0] e0;
    logic [7:0] e1;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.wr_en    = 1'b0;
    bus.wr_addr  = '0;
    bus.wr_data  = '0;
    bus.wr_mask  = '0;
    bus.rd0_addr = '0;
    bus.rd1_addr = '0;
    bus.clr_req  = 1'b0;
  endtask

  function automatic logic [7:0] merge(input logic [7:0] old, input logic [7:0] d,
                                       input logic [7:0] m);
    return (old & ~m) | (d & m);
  endfunction

  function automatic logic [7:0] m_read(input logic [1:0] a);
    logic [7:0] v;
    v = m_mem[a];
`ifdef REG_FILE_BYPASS_EN
    if (bus.wr_en && m_left == 0 && !bus.clr_req && a == bus.wr_addr)
      v = merge(m_mem[a], bus.wr_data, bus.wr_mask);
`endif
    return v;
  endfunction

  // Applies one clock edge worth of behaviour to the model.
  task automatic model_step();
    m_err  = bus.wr_en && (m_left > 0 || bus.clr_req);
    m_done = 1'b0;
    if (m_left > 0) begin
      m_mem[DEPTH - m_left] = 8'h00;
      m_left--;
      if (m_left == 0) m_done = 1'b1;
    end else if (bus.clr_req) begin
      m_left = DEPTH;
    end else if (bus.wr_en) begin
      m_mem[bus.wr_addr] = merge(m_mem[bus.wr_addr], bus.wr_data, bus.wr_mask);
    end
  endtask

  task automatic check_all_zero(input string name);
    for (int a = 0; a < DEPTH; a++) begin
      bus.rd0_addr = 2'(a);
      bus.rd1_addr = 2'(DEPTH - 1 - a);
      #1;
      chk({name, "_rd0"}, bus.rd0_data, 8'h00);
      chk({name, "_rd1"}, bus.rd1_data, 8'h00);
    end
  endtask

  initial begin
    int busy_cnt, done_cnt, fall_idx, done_idx;

    vecs[0] = '{1'b1, 2'd1, 8'hAA, 8'hFF, 2'd1, 2'd1, 8'hAA, 8'hAA};
    vecs[1] = '{1'b1, 2'd1, 8'h0F, 8'h0F, 2'd1, 2'd1, 8'hAF, 8'hAF};
    vecs[2] = '{1'b1, 2'd0, 8'h10, 8'hFF, 2'd0, 2'd1, 8'h10, 8'hAF};
    vecs[3] = '{1'b1, 2'd1, 8'h11, 8'hFF, 2'd1, 2'd0, 8'h11, 8'h10};
    vecs[4] = '{1'b1, 2'd2, 8'h12, 8'hFF, 2'd2, 2'd1, 8'h12, 8'h11};
    vecs[5] = '{1'b1, 2'd3, 8'h13, 8'hFF, 2'd0, 2'd3, 8'h10, 8'h13};
    vecs[6] = '{1'b0, 2'd0, 8'h00, 8'h00, 2'd1, 2'd2, 8'h11, 8'h12};
    vecs[7] = '{1'b1, 2'd2, 8'h5A, 8'h00, 2'd2, 2'd2, 8'h12, 8'h12};
    vecs[8] = '{1'b1, 2'd3, 8'hA5, 8'hF0, 2'd3, 2'd0, 8'hA3, 8'h10};

    // Reset state
    reset = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check_all_zero("reset");
    chk("reset_busy", bus.busy, 1'b0);
    chk("reset_wr_err", bus.wr_err, 1'b0);
    chk("reset_clr_done", bus.clr_done, 1'b0);

    // Directed table: back-to-back writes, masked merges, dual reads
    for (int i = 0; i < 9; i++) begin
      bus.wr_en    = vecs[i].we;
      bus.wr_addr  = vecs[i].wa;
      bus.wr_data  = vecs[i].wd;
      bus.wr_mask  = vecs[i].wm;
      bus.rd0_addr = vecs[i].r0;
      bus.rd1_addr = vecs[i].r1;
      tick();
      bus.wr_en = 1'b0;
      #1;
      chk($sformatf("vec%0d_rd0", i), bus.rd0_data, vecs[i].e0);
      chk($sformatf("vec%0d_rd1", i), bus.rd1_data, vecs[i].e1);
    end
    // contents now {10,11,12,A3}

    // Same-cycle read of the entry being written
    bus.wr_en = 1'b1; bus.wr_addr = 2'd2; bus.wr_data = 8'h55; bus.wr_mask = 8'hFF;
    bus.rd0_addr = 2'd2; bus.rd1_addr = 2'd3;
    #1;
`ifdef REG_FILE_BYPASS_EN
    chk("bypass_same_cycle", bus.rd0_data, 8'h55);
`else
    chk("nobypass_same_cycle", bus.rd0_data, 8'h12);
`endif
    chk("bypass_other_port", bus.rd1_data, 8'hA3);
    tick();
    bus.wr_en = 1'b0;
    #1;
    chk("write_next_cycle", bus.rd0_data, 8'h55);

    // Sweep with a colliding write
    bus.clr_req = 1'b1;
    tick();
    chk("sweep_busy_c1", bus.busy, 1'b1);
    bus.clr_req = 1'b0;
    bus.wr_en = 1'b1; bus.wr_addr = 2'd3; bus.wr_data = 8'h77; bus.wr_mask = 8'hFF;
    bus.rd0_addr = 2'd0; bus.rd1_addr = 2'd2;
    #1;
    chk("sweep_unswept0", bus.rd0_data, 8'h10);
    chk("sweep_no_err_yet", bus.wr_err, 1'b0);
    tick();
    chk("sweep_busy_c2", bus.busy, 1'b1);
    chk("sweep_wr_err", bus.wr_err, 1'b1);
    bus.wr_en = 1'b0;
    #1;
    chk("sweep_swept0", bus.rd0_data, 8'h00);
    chk("sweep_old2", bus.rd1_data, 8'h55);
    busy_cnt = 2; done_cnt = 0; fall_idx = -1; done_idx = -1;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (bus.busy) busy_cnt++;
      else if (fall_idx < 0) fall_idx = i;
      if (bus.clr_done) begin
        done_cnt++;
        done_idx = i;
      end
      chk("sweep_err_single", bus.wr_err, 1'b0);
    end
    chk("sweep_busy_len", busy_cnt, 4);
    chk("sweep_done_cnt", done_cnt, 1);
    chk("sweep_done_pos", done_idx, fall_idx);
    check_all_zero("sweep");

    // Reset during the second busy cycle
    bus.wr_en = 1'b1; bus.wr_addr = 2'd1; bus.wr_data = 8'h99; bus.wr_mask = 8'hFF;
    tick();
    bus.wr_en = 1'b0;
    bus.clr_req = 1'b1;
    tick();
    bus.clr_req = 1'b0;
    tick();
    chk("abort_busy_pre", bus.busy, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    chk("abort_busy", bus.busy, 1'b0);
    check_all_zero("abort");
    tick();
    reset = 1'b0;
    bus.wr_en = 1'b1; bus.wr_addr = 2'd0; bus.wr_data = 8'h3C; bus.wr_mask = 8'hFF;
    bus.rd0_addr = 2'd0;
    tick();
    bus.wr_en = 1'b0;
    #1;
    chk("first_write_after_reset", bus.rd0_data, 8'h3C);
    done_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      if (bus.clr_done || bus.busy) done_cnt++;
      tick();
    end
    chk("abort_no_done", done_cnt, 0);

    // Randomized traffic against the model
    reset = 1'b1;
    idle_inputs();
    #2;
    reset = 1'b0;
    for (int a = 0; a < DEPTH; a++) m_mem[a] = 8'h00;
    m_left = 0; m_done = 1'b0; m_err = 1'b0;
    for (int c = 0; c < 400; c++) begin
      chk("rnd_busy", bus.busy, (m_left > 0));
      chk("rnd_clr_done", bus.clr_done, m_done);
      chk("rnd_wr_err", bus.wr_err, m_err);
      bus.wr_en    = 1'($urandom_range(0, 1));
      bus.wr_addr  = 2'($urandom_range(0, 3));
      bus.wr_data  = 8'($urandom);
      bus.wr_mask  = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
      bus.clr_req  = ($urandom_range(0, 15) == 0);
      bus.rd0_addr = 2'($urandom_range(0, 3));
      bus.rd1_addr = 2'($urandom_range(0, 3));
      #1;
      chk("rnd_rd0", bus.rd0_data, m_read(bus.rd0_addr));
      chk("rnd_rd1", bus.rd1_data, m_read(bus.rd1_addr));
      @(posedge clk);
      model_step();
      #1;
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
`default_nettype wire
